// File: rtl/clock_timebase.sv
// Timekeeping core: 1 Hz prescaler, binary hh:mm:ss counters, button-driven time setting
// and the 0..5 digit-scan index for the display stage.
module clock_timebase #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned SCAN_DIV = 50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [6:0] hour,
  output logic [6:0] min,
  output logic [6:0] sec,
  output logic [3:0] selct,
  output logic [1:0] set_mode,
  output logic       tick_1hz
);

  localparam int unsigned PreW  = $clog2(CLK_FREQ);
  localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PreW-1:0]  PreMax  = PreW'(CLK_FREQ - 1);
  localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StSetHour = 2'd1,
    StSetMin  = 2'd2,
    StSetSec  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [1:0]       mode_sync_q, mode_sync_d, inc_sync_q, inc_sync_d;
  logic             mode_prev_q, mode_prev_d, inc_prev_q, inc_prev_d;
  logic [PreW-1:0]  presc_q, presc_d;
  logic [ScanW-1:0] scan_cnt_q, scan_cnt_d;
  logic [3:0]       selct_q, selct_d;
  logic [6:0]       hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic             tick_q, tick_d;
  logic             mode_evt, inc_evt, wrap, scan_wrap;

  // Two-flop synchronisers; prev holds the last synchronised value for edge detection.
  always_comb begin
    mode_sync_d = {mode_sync_q[0], btn_mode};
    inc_sync_d  = {inc_sync_q[0], btn_inc};
    mode_prev_d = mode_sync_q[1];
    inc_prev_d  = inc_sync_q[1];
    mode_evt    = mode_sync_q[1] & ~mode_prev_q;
    // A mode event on the same edge swallows the increment.
    inc_evt     = inc_sync_q[1] & ~inc_prev_q & ~mode_evt;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (mode_evt) begin
      unique case (state_q)
        StRun:     state_d = StSetHour;
        StSetHour: state_d = StSetMin;
        StSetMin:  state_d = StSetSec;
        StSetSec:  state_d = StRun;
        default:   state_d = StRun;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    set_mode = state_q;
  end

  // Prescaler and time counters
  always_comb begin
    wrap    = (state_q == StRun) && (presc_q == PreMax);
    tick_d  = wrap;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    // Only counts while staying in RUN, so re-entering RUN restarts a full second.
    if ((state_q == StRun) && (state_d == StRun)) begin
      presc_d = wrap ? '0 : presc_q + PreW'(1);
    end else begin
      presc_d = '0;
    end
    if (wrap) begin
      if (sec_q == 7'd59) begin
        sec_d = '0;
        if (min_q == 7'd59) begin
          min_d  = '0;
          hour_d = (hour_q == 7'd23) ? 7'd0 : hour_q + 7'd1;
        end else begin
          min_d = min_q + 7'd1;
        end
      end else begin
        sec_d = sec_q + 7'd1;
      end
    end else if (inc_evt) begin
      case (state_q)
        StSetHour: hour_d = (hour_q == 7'd23) ? 7'd0 : hour_q + 7'd1;
        StSetMin:  min_d  = (min_q == 7'd59) ? 7'd0 : min_q + 7'd1;
        StSetSec:  sec_d  = (sec_q == 7'd59) ? 7'd0 : sec_q + 7'd1;
        default:   ;
      endcase
    end
  end

  // Scan index runs in every state
  always_comb begin
    scan_wrap  = (scan_cnt_q == ScanMax);
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + ScanW'(1);
    selct_d    = selct_q;
    if (scan_wrap) begin
      selct_d = (selct_q == 4'd5) ? 4'd0 : selct_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_sync_q <= '0;
      inc_sync_q  <= '0;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      presc_q     <= '0;
      scan_cnt_q  <= '0;
      selct_q     <= '0;
      hour_q      <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      tick_q      <= 1'b0;
    end else begin
      mode_sync_q <= mode_sync_d;
      inc_sync_q  <= inc_sync_d;
      mode_prev_q <= mode_prev_d;
      inc_prev_q  <= inc_prev_d;
      presc_q     <= presc_d;
      scan_cnt_q  <= scan_cnt_d;
      selct_q     <= selct_d;
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      tick_q      <= tick_d;
    end
  end

  assign hour     = hour_q;
  assign min      = min_q;
  assign sec      = sec_q;
  assign selct    = selct_q;
  assign tick_1hz = tick_q;

endmodule

// File: tb/tb_clock_timebase.sv
// Directed bench for clock_timebase with CLK_FREQ=10, SCAN_DIV=2.
module tb_clock_timebase;

  logic       clk;
  logic       rst_n;
  logic       btn_mode;
  logic       btn_inc;
  logic [6:0] hour;
  logic [6:0] min;
  logic [6:0] sec;
  logic [3:0] selct;
  logic [1:0] set_mode;
  logic       tick_1hz;

  int tests;
  int fails;
  int tick_cnt;
  int tick_snap;

  clock_timebase #(
    .CLK_FREQ(10),
    .SCAN_DIV(2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .hour    (hour),
    .min     (min),
    .sec     (sec),
    .selct   (selct),
    .set_mode(set_mode),
    .tick_1hz(tick_1hz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (tick_1hz === 1'b1) tick_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hour"}, 32'(hour), 0);
    check({tag, "_min"}, 32'(min), 0);
    check({tag, "_sec"}, 32'(sec), 0);
    check({tag, "_selct"}, 32'(selct), 0);
    check({tag, "_mode"}, 32'(set_mode), 0);
    check({tag, "_tick"}, 32'(tick_1hz), 0);
  endtask

  // Pulse one cycle at a negedge; returns at the negedge after the effect edge (k+2).
  task automatic press_inc();
    btn_inc = 1'b1;
    @(negedge clk);
    btn_inc = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic press_mode();
    btn_mode = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    tick_cnt = 0;
    rst_n    = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    #1;
    check_all_zero("reset");

    // 1: first tick exactly at edge 10, one cycle wide
    @(negedge clk);
    rst_n = 1'b1;
    repeat (9) @(negedge clk);
    check("e9_sec", 32'(sec), 0);
    check("e9_tick", 32'(tick_1hz), 0);
    @(negedge clk);
    check("e10_sec", 32'(sec), 1);
    check("e10_tick", 32'(tick_1hz), 1);
    @(negedge clk);
    check("e11_tick", 32'(tick_1hz), 0);
    check("e11_sec", 32'(sec), 1);
    repeat (9) @(negedge clk);
    check("e20_sec", 32'(sec), 2);
    check("e20_tick", 32'(tick_1hz), 1);

    // 3: mode latency and hour wrap in SET_HOUR
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    btn_mode = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    check("mode_k", 32'(set_mode), 0);
    @(negedge clk);
    check("mode_k1", 32'(set_mode), 0);
    @(negedge clk);
    check("mode_k2", 32'(set_mode), 1);
    tick_snap = tick_cnt;
    repeat (25) press_inc();
    check("hour_wrap", 32'(hour), 1);
    check("hour_wrap_min", 32'(min), 0);
    check("hour_wrap_sec", 32'(sec), 0);
    check("frozen_ticks", 32'(tick_cnt), 32'(tick_snap));
    repeat (22) press_inc();
    check("hour_23", 32'(hour), 23);

    // 4: minute wrap without carry, then mode+inc on the same edge
    press_mode();
    check("set_min", 32'(set_mode), 2);
    repeat (59) press_inc();
    check("min_59", 32'(min), 59);
    press_inc();
    check("min_wrap", 32'(min), 0);
    check("min_wrap_hour", 32'(hour), 23);
    repeat (59) press_inc();
    btn_mode = 1'b1;
    btn_inc  = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("simul_mode", 32'(set_mode), 3);
    check("simul_min", 32'(min), 59);
    check("simul_sec", 32'(sec), 0);

    // 5a: holding inc gives exactly one event
    repeat (58) press_inc();
    check("sec_58", 32'(sec), 58);
    btn_inc = 1'b1;
    repeat (100) @(negedge clk);
    btn_inc = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_sec", 32'(sec), 59);
    check("hold_min", 32'(min), 59);
    check("hold_hour", 32'(hour), 23);

    // 2: back to RUN at 23:59:59, full rollover a full second later
    press_mode();
    check("run_mode", 32'(set_mode), 0);
    repeat (9) @(negedge clk);
    check("pre_roll_sec", 32'(sec), 59);
    check("pre_roll_tick", 32'(tick_1hz), 0);
    @(negedge clk);
    check("roll_hour", 32'(hour), 0);
    check("roll_min", 32'(min), 0);
    check("roll_sec", 32'(sec), 0);
    check("roll_tick", 32'(tick_1hz), 1);
    repeat (25) @(negedge clk);
    check("run_sec", 32'(sec), 2);

    // 5b: asynchronous reset mid-count
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");

    // 6: scan index sequence
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n <= 60; n++) begin
      check("selct_seq", 32'(selct), 32'((n / 2) % 6));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
